// File: rtl/ws2812_frame_sequencer_pkg.sv
// Shared types and constants for the WS2812 frame sequencer.
// Covers the decoder-s2 bit interface, sequencer states and forwarded-bit record.
package ws2812_frame_sequencer_pkg;

  localparam int BITS_PER_PIXEL_DEF = 24;
  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {SYNC = 2'd0, CAPTURE = 2'd1, FORWARD = 2'd2} seq_state_e;

  // State register encodings; these match seq_state_e.
  localparam logic [1:0] ST_SYNC    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_FORWARD = 2'd2;

  typedef struct packed {
    logic decode_bit;
    logic valid;
    logic treset;
  } shift_reg_input_t;

  typedef struct packed {
    logic fbit;
    logic valid;
  } fwd_output_t;

  localparam fwd_output_t reset_values_fwd = '{fbit: 1'b0, valid: 1'b0};

endpackage

// File: rtl/ws2812_frame_sequencer_shifter.sv
// Pixel assembly shift register with its bit counter.
// 'full' flags the shift that completes a word; 'word_next' is that word.
module ws2812_pixel_shifter
  import ws2812_frame_sequencer_pkg::*;
#(
  parameter int BPP = BITS_PER_PIXEL_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           shift_en,
  input  logic           clear,
  input  logic           in_bit,
  output logic [BPP-1:0] word_next,
  output logic           full,
  output logic           busy
);
  localparam int BC_W = $clog2(BPP + 1);

  logic [BPP-1:0]  shreg_q, shreg_d;
  logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    word_next = {shreg_q[BPP-2:0], in_bit};
    full      = shift_en && (bit_cnt_q == BC_W'(BPP - 1));
    busy      = (bit_cnt_q != '0);
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (clear) begin
      shreg_d   = '0;
      bit_cnt_d = '0;
    end else if (shift_en) begin
      // The completed word is handed off combinationally, so restart empty.
      if (full) begin
        shreg_d   = '0;
        bit_cnt_d = '0;
      end else begin
        shreg_d   = word_next;
        bit_cnt_d = bit_cnt_q + BC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// WS2812 frame sequencer: captures this node's pixel from each frame and
// forwards the remaining bits, tracking alignment, pixel count and errors.
module ws2812_frame_sequencer
  import ws2812_frame_sequencer_pkg::*;
#(
  parameter int BITS_PER_PIXEL = BITS_PER_PIXEL_DEF,
  parameter int MAX_PIXELS     = 1024,
  localparam int CNT_W         = $clog2(MAX_PIXELS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_bit,
  input  logic                      in_valid,
  input  logic                      in_treset,
  output logic [BITS_PER_PIXEL-1:0] pixel_data,
  output logic                      pixel_valid,
  input  logic                      pixel_ready,
  output logic                      fwd_bit,
  output logic                      fwd_valid,
  output logic                      frame_done,
  output logic                      short_frame,
  output logic                      overrun,
  output logic [CNT_W-1:0]          pixel_count,
  output logic                      synced
);
  localparam int BC_W = $clog2(BITS_PER_PIXEL + 1);
  localparam logic [CNT_W-1:0] PIX_MAX = CNT_W'(MAX_PIXELS);

  shift_reg_input_t in_s;
  logic [1:0] state_q, state_d;
  logic synced_q, synced_d;
  logic [BITS_PER_PIXEL-1:0] pixel_data_q, pixel_data_d;
  logic pixel_valid_q, pixel_valid_d;
  fwd_output_t fwd_q, fwd_d;
  logic frame_done_q, frame_done_d;
  logic short_frame_q, short_frame_d;
  logic overrun_q, overrun_d;
  logic [CNT_W-1:0] pixel_count_q, pixel_count_d;
  logic [CNT_W-1:0] frame_pix_q, frame_pix_d;
  logic [BC_W-1:0] fwd_bit_cnt_q, fwd_bit_cnt_d;

  logic sh_shift, sh_clear, sh_full, sh_busy;
  logic [BITS_PER_PIXEL-1:0] sh_word;

  ws2812_pixel_shifter #(.BPP(BITS_PER_PIXEL)) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (sh_shift),
    .clear     (sh_clear),
    .in_bit    (in_s.decode_bit),
    .word_next (sh_word),
    .full      (sh_full),
    .busy      (sh_busy)
  );

  always_comb begin
    in_s          = '{decode_bit: in_bit, valid: in_valid, treset: in_treset};
    state_d       = state_q;
    synced_d      = synced_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = pixel_valid_q;
    fwd_d         = reset_values_fwd;
    frame_done_d  = 1'b0;
    short_frame_d = 1'b0;
    overrun_d     = 1'b0;
    pixel_count_d = pixel_count_q;
    frame_pix_d   = frame_pix_q;
    fwd_bit_cnt_d = fwd_bit_cnt_q;
    sh_shift      = 1'b0;
    sh_clear      = 1'b0;

    if (pixel_valid_q && pixel_ready) pixel_valid_d = 1'b0;

    // treset takes priority over a coincident valid bit in every state.
    case (state_q)
      ST_SYNC: begin
        if (in_s.treset) begin
          state_d  = ST_CAPTURE;
          synced_d = 1'b1;
          sh_clear = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (in_s.treset) begin
          short_frame_d = sh_busy;
          sh_clear      = 1'b1;
        end else if (in_s.valid) begin
          sh_shift = 1'b1;
          if (sh_full) begin
            pixel_data_d  = sh_word;
            pixel_valid_d = 1'b1;
            overrun_d     = pixel_valid_q && !pixel_ready;
            state_d       = ST_FORWARD;
            fwd_bit_cnt_d = '0;
            frame_pix_d   = '0;
          end
        end
      end
      ST_FORWARD: begin
        if (in_s.treset) begin
          frame_done_d  = 1'b1;
          pixel_count_d = (frame_pix_q == PIX_MAX) ? PIX_MAX : frame_pix_q + CNT_W'(1);
          state_d       = ST_CAPTURE;
          fwd_bit_cnt_d = '0;
          frame_pix_d   = '0;
          sh_clear      = 1'b1;
        end else if (in_s.valid) begin
          fwd_d = '{fbit: in_s.decode_bit, valid: 1'b1};
          if (fwd_bit_cnt_q == BC_W'(BITS_PER_PIXEL - 1)) begin
            fwd_bit_cnt_d = '0;
            if (frame_pix_q != PIX_MAX) frame_pix_d = frame_pix_q + CNT_W'(1);
          end else begin
            fwd_bit_cnt_d = fwd_bit_cnt_q + BC_W'(1);
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_SYNC;
      synced_q      <= 1'b0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      fwd_q         <= reset_values_fwd;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
      overrun_q     <= 1'b0;
      pixel_count_q <= '0;
      frame_pix_q   <= '0;
      fwd_bit_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      synced_q      <= synced_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      fwd_q         <= fwd_d;
      frame_done_q  <= frame_done_d;
      short_frame_q <= short_frame_d;
      overrun_q     <= overrun_d;
      pixel_count_q <= pixel_count_d;
      frame_pix_q   <= frame_pix_d;
      fwd_bit_cnt_q <= fwd_bit_cnt_d;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign fwd_bit     = fwd_q.fbit;
  assign fwd_valid   = fwd_q.valid;
  assign frame_done  = frame_done_q;
  assign short_frame = short_frame_q;
  assign overrun     = overrun_q;
  assign pixel_count = pixel_count_q;
  assign synced      = synced_q;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Directed bench for ws2812_frame_sequencer: sync, capture, forward,
// short frames, overrun, coincident treset, mid-frame reset and saturation.
module tb_ws2812_frame_sequencer;
  logic        clk = 1'b0;
  logic        reset, in_bit, in_valid, in_treset, pixel_ready;
  logic [23:0] pixel_data;
  logic        pixel_valid, fwd_bit, fwd_valid, frame_done, short_frame, overrun, synced;
  logic [10:0] pixel_count;

  int checks = 0;
  int failures = 0;
  int n_fwd = 0, n_fd = 0, n_sf = 0, n_ov = 0;
  logic [63:0] fwd_sr = '0;

  always #5 clk = ~clk;

  ws2812_frame_sequencer dut (
    .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_treset(in_treset),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .fwd_bit(fwd_bit), .fwd_valid(fwd_valid), .frame_done(frame_done),
    .short_frame(short_frame), .overrun(overrun), .pixel_count(pixel_count), .synced(synced)
  );

  // Pulse and forwarded-stream monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (fwd_valid) begin
      n_fwd  = n_fwd + 1;
      fwd_sr = {fwd_sr[62:0], fwd_bit};
    end
    if (frame_done)  n_fd = n_fd + 1;
    if (short_frame) n_sf = n_sf + 1;
    if (overrun)     n_ov = n_ov + 1;
  end

  // One input cycle; on return the edge that consumed it has just passed.
  task automatic cyc(input logic v, input logic b, input logic t);
    in_valid = v; in_bit = b; in_treset = t;
    @(posedge clk); #1;
    in_valid = 1'b0; in_bit = 1'b0; in_treset = 1'b0;
  endtask

  task automatic send(input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(1'b1, w[i], 1'b0);
  endtask

  task automatic accept();
    pixel_ready = 1'b1; cyc(1'b0, 1'b0, 1'b0); pixel_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_bit = 0; in_valid = 0; in_treset = 0; pixel_ready = 0;
    repeat (2) @(posedge clk); #1;
    checks++; if ({pixel_valid, fwd_valid, frame_done, short_frame, overrun, synced} !== 6'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 000000",
        {pixel_valid, fwd_valid, frame_done, short_frame, overrun, synced}); end
    checks++; if (pixel_count !== 11'd0 || pixel_data !== 24'd0) begin
      failures++; $display("FAIL reset_data: got count=%0d data=%h expected 0/000000", pixel_count, pixel_data); end
    reset = 1'b0;
  endtask

  task automatic test_unsynced();
    int f0 = n_fwd;
    send(64'h0000_0000_ABCD_EF12, 32);
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (synced !== 1'b0) begin failures++; $display("FAIL unsynced_synced: got %b expected 0", synced); end
    checks++; if (n_fwd - f0 !== 0 || pixel_valid !== 1'b0) begin
      failures++; $display("FAIL unsynced_activity: got fwd=%0d pv=%b expected 0/0", n_fwd - f0, pixel_valid); end
  endtask

  task automatic test_basic_frame();
    int f0, d0;
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (synced !== 1'b1) begin failures++; $display("FAIL basic_synced: got %b expected 1", synced); end
    send(64'h0000_0000_00A5_F00F >> 1, 23);
    checks++; if (pixel_valid !== 1'b0) begin failures++; $display("FAIL basic_pv_early: got %b expected 0", pixel_valid); end
    send(64'h1, 1);
    checks++; if (pixel_valid !== 1'b1 || pixel_data !== 24'hA5F00F) begin
      failures++; $display("FAIL basic_pixel: got pv=%b data=%h expected 1/a5f00f", pixel_valid, pixel_data); end
    f0 = n_fwd; d0 = n_fd;
    send(64'h0000_1234_5678_9ABC, 48);
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (frame_done !== 1'b1 || pixel_count !== 11'd3) begin
      failures++; $display("FAIL basic_done: got fd=%b count=%0d expected 1/3", frame_done, pixel_count); end
    checks++; if (n_fwd - f0 !== 48 || fwd_sr[47:0] !== 48'h1234_5678_9ABC) begin
      failures++; $display("FAIL basic_fwd: got n=%0d bits=%h expected 48/123456789abc", n_fwd - f0, fwd_sr[47:0]); end
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (frame_done !== 1'b0 || n_fd - d0 !== 1 || pixel_data !== 24'hA5F00F) begin
      failures++; $display("FAIL basic_pulse: got fd=%b n=%0d data=%h expected 0/1/a5f00f", frame_done, n_fd - d0, pixel_data); end
    accept();
    checks++; if (pixel_valid !== 1'b0) begin failures++; $display("FAIL basic_accept: got %b expected 0", pixel_valid); end
  endtask

  task automatic test_short_frame();
    int s0 = n_sf, d0 = n_fd;
    send(64'h2AB, 10);
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (short_frame !== 1'b1 || pixel_valid !== 1'b0) begin
      failures++; $display("FAIL short_pulse: got sf=%b pv=%b expected 1/0", short_frame, pixel_valid); end
    send(64'h3C5A96, 24);
    checks++; if (pixel_valid !== 1'b1 || pixel_data !== 24'h3C5A96) begin
      failures++; $display("FAIL short_recapture: got pv=%b data=%h expected 1/3c5a96", pixel_valid, pixel_data); end
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (frame_done !== 1'b1 || pixel_count !== 11'd1) begin
      failures++; $display("FAIL short_done: got fd=%b count=%0d expected 1/1", frame_done, pixel_count); end
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (n_sf - s0 !== 1 || n_fd - d0 !== 1) begin
      failures++; $display("FAIL short_counts: got sf=%0d fd=%0d expected 1/1", n_sf - s0, n_fd - d0); end
    accept();
  endtask

  task automatic test_overrun();
    int o0 = n_ov;
    send(64'h111111, 24); cyc(1'b0, 1'b0, 1'b1);
    send(64'h222222, 24);
    checks++; if (overrun !== 1'b1 || pixel_data !== 24'h222222 || pixel_valid !== 1'b1) begin
      failures++; $display("FAIL ovr_pulse: got ov=%b data=%h pv=%b expected 1/222222/1", overrun, pixel_data, pixel_valid); end
    cyc(1'b0, 1'b0, 1'b1);
    send(64'h333333 >> 1, 23);
    pixel_ready = 1'b1; cyc(1'b1, 1'b1, 1'b0); pixel_ready = 1'b0;
    checks++; if (overrun !== 1'b0 || pixel_valid !== 1'b1 || pixel_data !== 24'h333333) begin
      failures++; $display("FAIL ovr_accept_same: got ov=%b pv=%b data=%h expected 0/1/333333", overrun, pixel_valid, pixel_data); end
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (n_ov - o0 !== 1) begin failures++; $display("FAIL ovr_count: got %0d expected 1", n_ov - o0); end
    accept();
  endtask

  task automatic test_coincident();
    int f0;
    send(64'h0F0F0F, 24);
    f0 = n_fwd;
    send(64'h16, 5);
    cyc(1'b1, 1'b1, 1'b1);
    checks++; if (frame_done !== 1'b1 || pixel_count !== 11'd1 || fwd_valid !== 1'b0) begin
      failures++; $display("FAIL coinc_done: got fd=%b count=%0d fv=%b expected 1/1/0", frame_done, pixel_count, fwd_valid); end
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (n_fwd - f0 !== 5 || fwd_sr[4:0] !== 5'h16) begin
      failures++; $display("FAIL coinc_fwd: got n=%0d bits=%h expected 5/16", n_fwd - f0, fwd_sr[4:0]); end
  endtask

  task automatic test_reset_midframe();
    send(64'h3FFFFFFF, 30);
    reset = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    checks++; if ({pixel_valid, fwd_valid, frame_done, short_frame, overrun, synced} !== 6'b0 ||
                  pixel_count !== 11'd0 || pixel_data !== 24'd0) begin
      failures++; $display("FAIL midreset_outputs: got flags=%b count=%0d data=%h expected 0",
        {pixel_valid, fwd_valid, frame_done, short_frame, overrun, synced}, pixel_count, pixel_data); end
    send(64'hFF, 8);
    checks++; if (fwd_valid !== 1'b0 || synced !== 1'b0 || pixel_valid !== 1'b0) begin
      failures++; $display("FAIL midreset_sync: got fv=%b synced=%b pv=%b expected 0/0/0", fwd_valid, synced, pixel_valid); end
  endtask

  task automatic test_saturate();
    int f0;
    cyc(1'b0, 1'b0, 1'b1);
    f0 = n_fwd;
    for (int p = 0; p < 1100; p++) send(64'(p) ^ 64'h5A5A5A, 24);
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (frame_done !== 1'b1 || pixel_count !== 11'd1024) begin
      failures++; $display("FAIL sat_count: got fd=%b count=%0d expected 1/1024", frame_done, pixel_count); end
    checks++; if (n_fwd - f0 !== 26376) begin failures++; $display("FAIL sat_fwd: got %0d expected 26376", n_fwd - f0); end
  endtask

  initial begin
    test_reset();
    test_unsynced();
    test_basic_frame();
    test_short_frame();
    test_overrun();
    test_coincident();
    test_reset_midframe();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
